vga_sync_out: RTL and testbench

- VGA timing generator and output stage that consumes the final pixel colour from the object/priority mux.
- Generates the pixelX/pixelY raster coordinates that all drawing objects use, and a once-per-frame tick for game logic.
- Takes the 24-bit RGB returned by the mux, applies blanking, and drives the DAC pins.
- Delays hsync, vsync and blank so they stay aligned with the mux's registered latency.

---
 rtl/vga_sync_out.sv | 177 +++++++++++++++++
 tb/tb_vga_sync_out.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_out.sv
// rtl/vga_sync_out.sv - VGA raster timing generator and blanked, latency-matched DAC output stage
//
// Purpose:
//   Counts the raster (hCnt/vCnt) and exports it as pixelX/pixelY for the
//   drawing objects. The object/priority mux returns a colour PIPE_DELAY
//   clocks later. The timing flags (active, hsync, vsync) are delayed by the
//   same amount so the output register sees the flags and the colour for the
//   same pixel. Colour is forced to zero outside active video. startOfFrame
//   pulses once per frame, at the first pixel of vertical blank, for game logic.
//
// Ports:
//   clk           in   1   pixel clock
//   resetN        in   1   asynchronous active-low reset
//   redIn         in   8   red from object mux (valid PIPE_DELAY clocks after pixelX/Y)
//   greenIn       in   8   green from object mux
//   blueIn        in   8   blue from object mux
//   pixelX        out  11  horizontal counter, 0..H_TOTAL-1
//   pixelY        out  11  vertical counter, 0..V_TOTAL-1
//   startOfFrame  out  1   one-clock pulse with pixelX=0, pixelY=V_ACTIVE
//   hsyncN        out  1   horizontal sync, active low
//   vsyncN        out  1   vertical sync, active low
//   blankN        out  1   low outside active video
//   vgaR/vgaG/vgaB out 8   colour to DAC, zero while blanked

module vga_sync_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int PIPE_DELAY = 1    // supported range 1..4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  redIn,
  input  logic [7:0]  greenIn,
  input  logic [7:0]  blueIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic        hsyncN,
  output logic        vsyncN,
  output logic        blankN,
  output logic [7:0]  vgaR,
  output logic [7:0]  vgaG,
  output logic [7:0]  vgaB
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_ACT_LAST = 11'(V_ACTIVE - 1);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Raster counters
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;
  logic        w_h_last;
  logic        w_v_last;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_last) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_last ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  assign pixelX = r_h_cnt;
  assign pixelY = r_v_cnt;

  // Raw timing flags for the pixel the counters point at right now
  logic w_active;
  logic w_hs;
  logic w_vs;

  assign w_active = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
  assign w_hs     = (r_h_cnt >= HS_START) && (r_h_cnt <= HS_END);
  assign w_vs     = (r_v_cnt >= VS_START) && (r_v_cnt <= VS_END);

  // Flag delay line. After PIPE_DELAY stages the flags belong to the same pixel
  // as the colour arriving from the mux. Clearing it on reset keeps partial sync
  // pulses and stale colour from leaking out after a mid-frame reset.
  logic [PIPE_DELAY-1:0] r_active_sr;
  logic [PIPE_DELAY-1:0] r_hs_sr;
  logic [PIPE_DELAY-1:0] r_vs_sr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_active_sr <= '0;
      r_hs_sr     <= '0;
      r_vs_sr     <= '0;
    end else begin
      r_active_sr[0] <= w_active;
      r_hs_sr[0]     <= w_hs;
      r_vs_sr[0]     <= w_vs;
      for (int i = 1; i < PIPE_DELAY; i++) begin
        r_active_sr[i] <= r_active_sr[i-1];
        r_hs_sr[i]     <= r_hs_sr[i-1];
        r_vs_sr[i]     <= r_vs_sr[i-1];
      end
    end
  end

  logic w_active_d;
  logic w_hs_d;
  logic w_vs_d;

  assign w_active_d = r_active_sr[PIPE_DELAY-1];
  assign w_hs_d     = r_hs_sr[PIPE_DELAY-1];
  assign w_vs_d     = r_vs_sr[PIPE_DELAY-1];

  // Output register: sync, blank and colour all leave on the same edge
  logic       r_hsync_n;
  logic       r_vsync_n;
  logic       r_blank_n;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_hsync_n <= 1'b1;
      r_vsync_n <= 1'b1;
      r_blank_n <= 1'b0;
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
    end else begin
      r_hsync_n <= ~w_hs_d;
      r_vsync_n <= ~w_vs_d;
      r_blank_n <= w_active_d;
      r_red     <= w_active_d ? redIn   : 8'h00;
      r_green   <= w_active_d ? greenIn : 8'h00;
      r_blue    <= w_active_d ? blueIn  : 8'h00;
    end
  end

  assign hsyncN = r_hsync_n;
  assign vsyncN = r_vsync_n;
  assign blankN = r_blank_n;
  assign vgaR   = r_red;
  assign vgaG   = r_green;
  assign vgaB   = r_blue;

  // Frame tick. This is deliberately not delayed: game logic wants it on the
  // counter timeline, so it lines up with pixelX=0, pixelY=V_ACTIVE.
  logic r_sof;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sof <= 1'b0;
    end else begin
      r_sof <= w_h_last && (r_v_cnt == V_ACT_LAST);
    end
  end

  assign startOfFrame = r_sof;

endmodule

// File: tb/tb_vga_sync_out.sv
// tb/tb_vga_sync_out.sv - scoreboard testbench for vga_sync_out on a reduced raster, PIPE_DELAY 1 and 3

module tb_vga_sync_out;

  localparam int HA  = 16;
  localparam int HF  = 2;
  localparam int HSW = 4;
  localparam int HB  = 3;
  localparam int VA  = 8;
  localparam int VF  = 2;
  localparam int VSW = 2;
  localparam int VB  = 3;
  localparam int HT  = HA + HF + HSW + HB;   // 25
  localparam int VT  = VA + VF + VSW + VB;   // 15
  localparam int PDA = 1;
  localparam int PDB = 3;

  localparam logic [26:0] RESET_PINS = {1'b1, 1'b1, 1'b0, 24'h000000};

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic ff_mode = 1'b1;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // DUT A: PIPE_DELAY = 1
  logic [7:0]  a_rin, a_gin, a_bin;
  logic [10:0] a_px, a_py;
  logic        a_sof, a_hs, a_vs, a_bl;
  logic [7:0]  a_R, a_G, a_B;
  // DUT B: PIPE_DELAY = 3
  logic [7:0]  b_rin, b_gin, b_bin;
  logic [10:0] b_px, b_py;
  logic        b_sof, b_hs, b_vs, b_bl;
  logic [7:0]  b_R, b_G, b_B;

  vga_sync_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DELAY(PDA)
  ) u_a (
    .clk(clk), .resetN(resetN),
    .redIn(a_rin), .greenIn(a_gin), .blueIn(a_bin),
    .pixelX(a_px), .pixelY(a_py), .startOfFrame(a_sof),
    .hsyncN(a_hs), .vsyncN(a_vs), .blankN(a_bl),
    .vgaR(a_R), .vgaG(a_G), .vgaB(a_B)
  );

  vga_sync_out #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB), .PIPE_DELAY(PDB)
  ) u_b (
    .clk(clk), .resetN(resetN),
    .redIn(b_rin), .greenIn(b_gin), .blueIn(b_bin),
    .pixelX(b_px), .pixelY(b_py), .startOfFrame(b_sof),
    .hsyncN(b_hs), .vsyncN(b_vs), .blankN(b_bl),
    .vgaR(b_R), .vgaG(b_G), .vgaB(b_B)
  );

  // Model of the object mux: colour derived from pixelX, delayed PIPE_DELAY clocks
  logic [7:0] da = 8'h00;
  logic [7:0] db0 = 8'h00, db1 = 8'h00, db2 = 8'h00;

  always @(posedge clk) begin
    da  <= a_px[7:0];
    db0 <= b_px[7:0];
    db1 <= db0;
    db2 <= db1;
  end

  assign a_rin = ff_mode ? 8'hFF : da;
  assign a_gin = ff_mode ? 8'hFF : ~da;
  assign a_bin = ff_mode ? 8'hFF : (da ^ 8'h5A);
  assign b_rin = ff_mode ? 8'hFF : db2;
  assign b_gin = ff_mode ? 8'hFF : ~db2;
  assign b_bin = ff_mode ? 8'hFF : (db2 ^ 8'h5A);

  logic [26:0] pins_a, pins_b;
  assign pins_a = {a_hs, a_vs, a_bl, a_R, a_G, a_B};
  assign pins_b = {b_hs, b_vs, b_bl, b_R, b_G, b_B};

  // Reference raster and pin scoreboard
  int mh = 0;
  int mv = 0;
  logic [26:0] qa[$];
  logic [26:0] qb[$];

  function automatic logic [26:0] exp_pins(input int h, input int v, input logic ff);
    logic act, hs, vs;
    logic [7:0] p;
    act = (h < HA) && (v < VA);
    hs  = (h >= HA + HF) && (h < HA + HF + HSW);
    vs  = (v >= VA + VF) && (v < VA + VF + VSW);
    p   = 8'(h);
    if (!act) return {~hs, ~vs, 1'b0, 24'h000000};
    if (ff)   return {~hs, ~vs, 1'b1, 24'hFFFFFF};
    return {~hs, ~vs, 1'b1, p, ~p, p ^ 8'h5A};
  endfunction

  // Called at a negedge with resetN low; the pipelines hold reset values for PD+1 clocks
  task automatic release_reset();
    resetN = 1'b1;
    mh = 0;
    mv = 0;
    qa.delete();
    qb.delete();
    for (int i = 0; i < PDA + 1; i++) qa.push_back(RESET_PINS);
    for (int i = 0; i < PDB + 1; i++) qb.push_back(RESET_PINS);
  endtask

  task automatic advance();
    @(posedge clk);
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    @(negedge clk);
  endtask

  task automatic sb_step(output logic [26:0] ea, output logic [26:0] eb);
    qa.push_back(exp_pins(mh, mv, ff_mode));
    qb.push_back(exp_pins(mh, mv, ff_mode));
    ea = qa.pop_front();
    eb = qb.pop_front();
  endtask

  task automatic test_reset();
    ff_mode = 1'b1;
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pins_a !== RESET_PINS) begin
      failures++; $display("FAIL reset_pins_a got=%h want=%h", pins_a, RESET_PINS);
    end
    checks++;
    if (pins_b !== RESET_PINS) begin
      failures++; $display("FAIL reset_pins_b got=%h want=%h", pins_b, RESET_PINS);
    end
    checks++;
    if (a_px !== 11'd0 || a_py !== 11'd0 || b_px !== 11'd0 || b_py !== 11'd0) begin
      failures++; $display("FAIL reset_xy got=%0d,%0d want=0,0", a_px, a_py);
    end
    checks++;
    if (a_sof !== 1'b0 || b_sof !== 1'b0) begin
      failures++; $display("FAIL reset_sof got=%b want=0", a_sof);
    end
  endtask

  task automatic test_counters_alignment();
    logic [26:0] ea, eb;
    int sof_a, sof_b;
    sof_a = 0;
    sof_b = 0;
    ff_mode = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    release_reset();
    for (int n = 0; n < 2 * HT * VT; n++) begin
      sb_step(ea, eb);
      checks++;
      if (pins_a !== ea) begin
        failures++; $display("FAIL align_pd1 n=%0d got=%h want=%h", n, pins_a, ea);
      end
      checks++;
      if (pins_b !== eb) begin
        failures++; $display("FAIL align_pd3 n=%0d got=%h want=%h", n, pins_b, eb);
      end
      checks++;
      if (a_px !== 11'(mh) || a_py !== 11'(mv) || b_px !== 11'(mh) || b_py !== 11'(mv)) begin
        failures++; $display("FAIL raster n=%0d got=%0d,%0d want=%0d,%0d", n, a_px, a_py, mh, mv);
      end
      checks++;
      if (a_sof !== (mh == 0 && mv == VA) || b_sof !== (mh == 0 && mv == VA)) begin
        failures++; $display("FAIL sof_pos n=%0d got=%b want=%b", n, a_sof, (mh == 0 && mv == VA));
      end
      if (n == HT - 1) begin
        checks++;
        if (a_px !== 11'(HT - 1) || a_py !== 11'd0) begin
          failures++; $display("FAIL line_end got=%0d,%0d want=%0d,0", a_px, a_py, HT - 1);
        end
      end
      if (n == HT) begin
        checks++;
        if (a_px !== 11'd0 || a_py !== 11'd1) begin
          failures++; $display("FAIL line_wrap got=%0d,%0d want=0,1", a_px, a_py);
        end
      end
      if (n == HT * VT) begin
        checks++;
        if (a_px !== 11'd0 || a_py !== 11'd0) begin
          failures++; $display("FAIL frame_wrap got=%0d,%0d want=0,0", a_px, a_py);
        end
      end
      if (a_sof === 1'b1) sof_a++;
      if (b_sof === 1'b1) sof_b++;
      advance();
    end
    checks++;
    if (sof_a != 2 || sof_b != 2) begin
      failures++; $display("FAIL sof_count got=%0d,%0d want=2", sof_a, sof_b);
    end
  endtask

  task automatic test_sync_widths();
    logic prev_hs, prev_vs, prev_bhs;
    int a_fall, b_fall, last_fall, hs_run, hs_runs, vs_fall, vs_run, vs_runs;
    ff_mode = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    release_reset();
    prev_hs = 1'b1; prev_vs = 1'b1; prev_bhs = 1'b1;
    a_fall = -1; b_fall = -1; last_fall = -1; vs_fall = -1;
    hs_run = 0; hs_runs = 0; vs_run = 0; vs_runs = 0;
    for (int n = 0; n < HT * VT + HT; n++) begin
      if (prev_hs && !a_hs) begin
        if (a_fall < 0) a_fall = n;
        else begin
          checks++;
          if (n - last_fall != HT) begin
            failures++; $display("FAIL hs_period n=%0d got=%0d want=%0d", n, n - last_fall, HT);
          end
        end
        last_fall = n;
      end
      if (!prev_hs && a_hs) begin
        checks++;
        if (hs_run != HSW) begin
          failures++; $display("FAIL hs_width n=%0d got=%0d want=%0d", n, hs_run, HSW);
        end
        hs_runs++;
      end
      hs_run = a_hs ? 0 : hs_run + 1;
      if (prev_vs && !a_vs && vs_fall < 0) vs_fall = n;
      if (!prev_vs && a_vs) begin
        checks++;
        if (vs_run != VSW * HT) begin
          failures++; $display("FAIL vs_width got=%0d want=%0d", vs_run, VSW * HT);
        end
        vs_runs++;
      end
      vs_run = a_vs ? 0 : vs_run + 1;
      if (prev_bhs && !b_hs && b_fall < 0) b_fall = n;
      prev_hs = a_hs; prev_vs = a_vs; prev_bhs = b_hs;
      advance();
    end
    checks++;
    if (a_fall != HA + HF + 2) begin
      failures++; $display("FAIL hs_first_pd1 got=%0d want=%0d", a_fall, HA + HF + 2);
    end
    checks++;
    if (b_fall != HA + HF + PDB + 1) begin
      failures++; $display("FAIL hs_first_pd3 got=%0d want=%0d", b_fall, HA + HF + PDB + 1);
    end
    checks++;
    if (hs_runs != VT + 1) begin
      failures++; $display("FAIL hs_pulses got=%0d want=%0d", hs_runs, VT + 1);
    end
    checks++;
    if (vs_fall != (VA + VF) * HT + 2 || vs_runs != 1) begin
      failures++; $display("FAIL vs_start got=%0d/%0d want=%0d/1", vs_fall, vs_runs, (VA + VF) * HT + 2);
    end
  endtask

  task automatic test_blanking();
    logic [26:0] ea, eb;
    logic exp_on;
    int on_cnt;
    on_cnt = 0;
    ff_mode = 1'b1;
    resetN = 1'b0;
    @(negedge clk);
    release_reset();
    for (int n = 0; n < HT * VT; n++) begin
      sb_step(ea, eb);
      checks++;
      if (pins_a !== ea || pins_b !== eb) begin
        failures++; $display("FAIL blank_sb n=%0d got=%h/%h want=%h/%h", n, pins_a, pins_b, ea, eb);
      end
      exp_on = (n >= 2) && (((n - 2) % HT) < HA) && (((n - 2) / HT) < VA);
      checks++;
      if (a_bl !== exp_on || a_R !== (exp_on ? 8'hFF : 8'h00) || a_B !== (exp_on ? 8'hFF : 8'h00)) begin
        failures++; $display("FAIL blank_window n=%0d got=%b/%h want=%b", n, a_bl, a_R, exp_on);
      end
      if (a_bl === 1'b1) on_cnt++;
      advance();
    end
    checks++;
    if (on_cnt != HA * VA) begin
      failures++; $display("FAIL blank_count got=%0d want=%0d", on_cnt, HA * VA);
    end
  endtask

  task automatic test_reset_midline();
    logic [26:0] ea, eb;
    logic found;
    ff_mode = 1'b0;
    resetN = 1'b0;
    @(negedge clk);
    release_reset();
    // reset while hsyncN is low
    found = 1'b0;
    for (int n = 0; n < 2 * HT * VT && !found; n++) begin
      if (mh == HA + HF + 3 && mv == 3) found = 1'b1;
      else advance();
    end
    checks++;
    if (!found || a_hs !== 1'b0) begin
      failures++; $display("FAIL mid_hs_pre got=%b/%b want=1/0", found, a_hs);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (a_hs !== 1'b1 || a_bl !== 1'b0 || a_R !== 8'h00 || a_px !== 11'd0 || a_py !== 11'd0) begin
      failures++; $display("FAIL mid_hs_async got=%b/%b/%h/%0d/%0d want=1/0/00/0/0", a_hs, a_bl, a_R, a_px, a_py);
    end
    checks++;
    if (pins_b !== RESET_PINS) begin
      failures++; $display("FAIL mid_hs_async_pd3 got=%h want=%h", pins_b, RESET_PINS);
    end
    @(negedge clk);
    release_reset();
    for (int n = 0; n < HT + 5; n++) begin
      sb_step(ea, eb);
      checks++;
      if (pins_a !== ea || pins_b !== eb || a_px !== 11'(mh) || a_py !== 11'(mv)) begin
        failures++; $display("FAIL mid_restart n=%0d got=%h,%0d,%0d want=%h,%0d,%0d", n, pins_a, a_px, a_py, ea, mh, mv);
      end
      advance();
    end
    // reset while colour is being driven
    found = 1'b0;
    for (int n = 0; n < 2 * HT * VT && !found; n++) begin
      if (mh == 10 && mv == 2) found = 1'b1;
      else advance();
    end
    checks++;
    if (!found || a_R !== 8'd8 || b_R !== 8'd6) begin
      failures++; $display("FAIL mid_act_pre got=%b/%h/%h want=1/08/06", found, a_R, b_R);
    end
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (a_R !== 8'h00 || a_bl !== 1'b0 || b_R !== 8'h00 || b_bl !== 1'b0 || a_px !== 11'd0) begin
      failures++; $display("FAIL mid_act_async got=%h/%b/%h/%b/%0d want=00/0/00/0/0", a_R, a_bl, b_R, b_bl, a_px);
    end
    @(negedge clk);
    release_reset();
  endtask

  initial begin
    test_reset();
    test_counters_alignment();
    test_sync_widths();
    test_blanking();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
